// File: rtl/gray_sched_pkg.sv
// gray_sched_pkg
// Shared definitions for the Gray conversion scheduler.
//   state_t  : scheduler FSM states (IDLE, GRANT, RESULT)
//   bin2gray : binary-to-Gray conversion; callers zero-extend their operand
//              to GRAY_MAX_W bits and truncate the result back to their own
//              width, which makes the one function usable for any word width
//              up to GRAY_MAX_W.
package gray_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam int GRAY_MAX_W = 32;

  // Zero-extension keeps the MSB rule intact: the bit above the operand's
  // MSB is 0, so g[msb] = b[msb] ^ 0 = b[msb].
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin winner search.
// Ports:
//   req  [N_REQ-1:0] : request vector
//   ptr  [IDW-1:0]   : index searched first; search proceeds upward, wrapping
//   gnt  [N_REQ-1:0] : one-hot winner (all zero when no request)
//   idx  [IDW-1:0]   : index of the winner (0 when no request)
//   hit              : at least one request is asserted
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   idx,
  output logic             hit
);

  logic [IDW-1:0] cand;

  // Walk the N_REQ candidates starting at ptr; the first asserted request
  // wins and later ones are masked by hit.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    hit  = 1'b0;
    cand = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDW'((int'(ptr) + i) % N_REQ);
      if (!hit && req[cand]) begin
        hit       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/gray_conv_scheduler.sv
// gray_conv_scheduler
// Arbitrates N_REQ requesters round-robin, converts the winner's binary
// operand to Gray code and presents it with a valid/ready handshake.
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_req [N_REQ]     : level-held requests, dropped once the grant is seen
//   i_binary          : packed operands, slice k belongs to requester k
//   o_gnt [N_REQ]     : one-hot grant, one cycle per accepted request
//   o_gray [WIDTH]    : registered Gray result
//   o_id              : index of the requester owning o_gray
//   o_valid, i_ready  : result handshake; transfer when both are high
//   o_busy            : high whenever the scheduler is not idle
module gray_conv_scheduler
  import gray_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*WIDTH-1:0]   i_binary,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [WIDTH-1:0]         o_gray,
  output logic [$clog2(N_REQ)-1:0] o_id,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_busy
);

  localparam int IDW = $clog2(N_REQ);

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   lat_id;
  logic [WIDTH-1:0] lat_op;

  logic [N_REQ-1:0] win_gnt;
  logic [IDW-1:0]   win_idx;
  logic             win_hit;
  logic [WIDTH-1:0] win_op;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .IDW  (IDW)
  ) u_arbiter (
    .req(i_req),
    .ptr(ptr),
    .gnt(win_gnt),
    .idx(win_idx),
    .hit(win_hit)
  );

  // Operand mux written with constant slice offsets so no wide computed
  // part-select index is needed.
  always_comb begin
    win_op = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (IDW'(k) == win_idx) begin
        win_op = i_binary[k*WIDTH +: WIDTH];
      end
    end
  end

  // The operand is captured at grant time, so whatever the requester does
  // with i_req/i_binary afterwards cannot disturb the conversion. Requests
  // seen outside IDLE are simply not looked at.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      ptr     <= '0;
      lat_id  <= '0;
      lat_op  <= '0;
      o_gnt   <= '0;
      o_gray  <= '0;
      o_id    <= '0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_hit) begin
            lat_id <= win_idx;
            lat_op <= win_op;
            o_gnt  <= win_gnt;
            state  <= GRANT;
          end
        end
        GRANT: begin
          o_gray  <= WIDTH'(bin2gray(GRAY_MAX_W'(lat_op)));
          o_id    <= lat_id;
          o_valid <= 1'b1;
          o_gnt   <= '0;
          state   <= RESULT;
        end
        RESULT: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            ptr     <= IDW'((int'(o_id) + 1) % N_REQ);
            state   <= IDLE;
          end
        end
        default: begin
          o_gnt   <= '0;
          o_valid <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign o_busy = (state != IDLE);

endmodule
